// File: rtl/dsp_feeder_pkg.sv
// Shared types and constants for the DSP sample feeder.
package dsp_feeder_pkg;

    localparam int SAMPLE_W        = 16;
    localparam int COEFF_IDX_W     = 4;
    localparam int DEFAULT_TIMEOUT = 63;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        COEFF = 2'd3
    } feeder_state_e;

endpackage

// File: rtl/dsp_sync_fifo.sv
// Single-clock FIFO with registered occupancy; the head word is visible
// combinationally so the consumer can capture it on the pop edge.
module dsp_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_LVL = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   level_q;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_o    = (level_q == FULL_LVL);
    assign empty_o   = (level_q == '0);
    assign push_ok_s = push_i & ~full_o;
    assign pop_ok_s  = pop_i & ~empty_o;
    assign head_o    = mem_q[rd_ptr_q];
    assign level_o   = level_q;

    // Storage, pointers and occupancy; a simultaneous push and pop keeps the level.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_ok_s) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_q <= level_q + (PTR_W + 1)'(1);
                2'b01:   level_q <= level_q - (PTR_W + 1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/dsp_sample_feeder.sv
// Feeds buffered samples to the DSP engine one at a time, replays the
// coefficient shadow bank as bursts between samples, and watches for an
// engine that never completes.
module dsp_sample_feeder
    import dsp_feeder_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int NUM_COEFFS = 16,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [SAMPLE_W-1:0]          s_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic                         coeff_wr,
    input  logic [COEFF_IDX_W-1:0]       coeff_addr,
    input  logic [SAMPLE_W-1:0]          coeff_wdata,
    input  logic                         coeff_commit,
    output logic [SAMPLE_W-1:0]          sample_in,
    output logic                         sample_valid,
    input  logic                         sample_ready,
    output logic [SAMPLE_W-1:0]          coeff_in,
    output logic                         coeff_load,
    output logic                         busy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         err_timeout,
    input  logic                         err_clear
);

    localparam logic [COEFF_IDX_W-1:0] LAST_IDX = COEFF_IDX_W'(NUM_COEFFS - 1);
    localparam logic [7:0]             WD_LIMIT = 8'(TIMEOUT);

    feeder_state_e          state_q, state_d;
    logic                   pending_q, pending_d;
    logic [7:0]             wd_q, wd_d;
    logic [COEFF_IDX_W-1:0] idx_q, idx_d;
    logic [SAMPLE_W-1:0]    sample_in_q, sample_in_d;
    logic                   sample_valid_q, sample_valid_d;
    logic [SAMPLE_W-1:0]    coeff_in_q, coeff_in_d;
    logic                   coeff_load_q, coeff_load_d;
    logic                   busy_q, busy_d;
    logic                   err_q, err_d;
    logic [SAMPLE_W-1:0]    shadow_q [NUM_COEFFS];

    logic                   fifo_pop_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    logic [SAMPLE_W-1:0]    fifo_head_s;
    logic                   timeout_s;
    logic                   pend_clr_s;
    logic                   shadow_we_s;
    logic [COEFF_IDX_W-1:0] rd_idx_s;
    logic [SAMPLE_W-1:0]    coeff_rd_s;

    assign s_ready      = ~fifo_full_s;
    assign shadow_we_s  = coeff_wr & (int'(coeff_addr) < NUM_COEFFS);
    assign sample_in    = sample_in_q;
    assign sample_valid = sample_valid_q;
    assign coeff_in     = coeff_in_q;
    assign coeff_load   = coeff_load_q;
    assign busy         = busy_q;
    assign err_timeout  = err_q;

    dsp_sync_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (s_valid & s_ready),
        .data_i  (s_data),
        .pop_i   (fifo_pop_s),
        .head_o  (fifo_head_s),
        .level_o (fifo_level),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Next-state logic: FSM, burst index, watchdog, commit latch and error flag.
    always_comb begin
        state_d        = state_q;
        wd_d           = wd_q;
        idx_d          = idx_q;
        sample_in_d    = sample_in_q;
        sample_valid_d = 1'b0;
        coeff_in_d     = '0;
        coeff_load_d   = 1'b0;
        fifo_pop_s     = 1'b0;
        timeout_s      = 1'b0;
        pend_clr_s     = 1'b0;

        // The burst reads the live bank; a write landing on the same edge is forwarded.
        rd_idx_s = (state_q == COEFF) ? idx_q : '0;
        if (shadow_we_s && (coeff_addr == rd_idx_s)) begin
            coeff_rd_s = coeff_wdata;
        end else begin
            coeff_rd_s = shadow_q[rd_idx_s];
        end

        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    // Commits win over samples so the engine never sees stale taps.
                    pend_clr_s   = 1'b1;
                    coeff_load_d = 1'b1;
                    coeff_in_d   = coeff_rd_s;
                    idx_d        = COEFF_IDX_W'(1);
                    state_d      = COEFF;
                end else if (!fifo_empty_s) begin
                    fifo_pop_s  = 1'b1;
                    sample_in_d = fifo_head_s;
                    state_d     = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                sample_valid_d = 1'b1;
                wd_d           = 8'd0;
                state_d        = WAIT;
            end
            WAIT: begin
                if (sample_ready) begin
                    state_d = IDLE;
                end else if (wd_q == WD_LIMIT) begin
                    timeout_s = 1'b1;
                    state_d   = IDLE;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
            end
            COEFF: begin
                coeff_load_d = 1'b1;
                coeff_in_d   = coeff_rd_s;
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + COEFF_IDX_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A commit arriving on the same edge the latch is consumed stays pending.
        if (coeff_commit) begin
            pending_d = 1'b1;
        end else if (pend_clr_s) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end

        // Setting the timeout flag beats a simultaneous clear.
        if (timeout_s) begin
            err_d = 1'b1;
        end else if (err_clear) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end

        busy_d = (state_d != IDLE) | pending_d;
    end

    // State, output and shadow-bank registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            pending_q      <= 1'b0;
            wd_q           <= 8'd0;
            idx_q          <= '0;
            sample_in_q    <= '0;
            sample_valid_q <= 1'b0;
            coeff_in_q     <= '0;
            coeff_load_q   <= 1'b0;
            busy_q         <= 1'b0;
            err_q          <= 1'b0;
            for (int i = 0; i < NUM_COEFFS; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            wd_q           <= wd_d;
            idx_q          <= idx_d;
            sample_in_q    <= sample_in_d;
            sample_valid_q <= sample_valid_d;
            coeff_in_q     <= coeff_in_d;
            coeff_load_q   <= coeff_load_d;
            busy_q         <= busy_d;
            err_q          <= err_d;
            if (shadow_we_s) begin
                shadow_q[coeff_addr] <= coeff_wdata;
            end
        end
    end

endmodule

// File: tb/tb_dsp_sample_feeder.sv
// Scoreboard bench for dsp_sample_feeder with a behavioural engine model.
module tb_dsp_sample_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] s_data = 16'd0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        coeff_wr = 1'b0;
    logic [3:0]  coeff_addr = 4'd0;
    logic [15:0] coeff_wdata = 16'd0;
    logic        coeff_commit = 1'b0;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic        sample_ready = 1'b0;
    logic [15:0] coeff_in;
    logic        coeff_load;
    logic        busy;
    logic [3:0]  fifo_level;
    logic        err_timeout;
    logic        err_clear = 1'b0;

    dsp_sample_feeder dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .coeff_wr(coeff_wr), .coeff_addr(coeff_addr), .coeff_wdata(coeff_wdata),
        .coeff_commit(coeff_commit), .sample_in(sample_in), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .coeff_in(coeff_in), .coeff_load(coeff_load),
        .busy(busy), .fifo_level(fifo_level), .err_timeout(err_timeout), .err_clear(err_clear)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [15:0] sq[$];
    int          cq[$];
    logic [15:0] c15[$];
    logic [15:0] mdl_shadow [16];

    int  sv_cnt = 0, load_cnt = 0, run = 0, max_level = 0;
    int  push_cyc = 0, last_sv = 0, eng_cnt = 0;
    bit  eng_on = 1'b1, eng_active = 1'b0, lat_chk = 1'b0, per_chk = 1'b0, have_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor followed by the engine model (ready pulse 19 cycles after issue).
    always @(negedge clk) begin
        if (rst) begin
            eng_active   = 1'b0;
            sample_ready = 1'b0;
            run          = 0;
        end else begin
            chk("s_ready", s_ready, fifo_level != 4'd8);
            if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
            if (sample_valid) begin
                sv_cnt++;
                chk("sv_after_burst", cq.size(), 0);
                chk("sq_has_entry", sq.size() != 0, 1);
                if (sq.size() != 0) chk("sample_in", sample_in, sq.pop_front());
                if (lat_chk) chk("latency", cyc - push_cyc, 2);
                if (per_chk && have_prev) chk("period", cyc - last_sv, 22);
                have_prev = 1'b1;
                last_sv   = cyc;
            end
            if (coeff_load) begin
                int ix;
                chk("coeff_vs_inflight", eng_active, 0);
                run++;
                load_cnt++;
                chk("cq_has_entry", cq.size() != 0, 1);
                if (cq.size() != 0) begin
                    ix = cq.pop_front();
                    chk("coeff_in", coeff_in, mdl_shadow[ix]);
                    if (ix == 15) c15.push_back(coeff_in);
                end
            end else begin
                chk("coeff_in_zero", coeff_in, 0);
                if (run != 0) begin
                    chk("burst_len", run % 16, 0);
                    run = 0;
                end
            end
            sample_ready = 1'b0;
            if (eng_active) begin
                eng_cnt++;
                if (eng_cnt == 19) begin
                    sample_ready = 1'b1;
                    eng_active   = 1'b0;
                end
            end
            if (sample_valid && eng_on) begin
                eng_active = 1'b1;
                eng_cnt    = 0;
            end
        end
    end

    task automatic push_one(input logic [15:0] d, input bit keep);
        bit acc = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        for (int t = 0; t < 500 && !acc; t++) begin
            @(negedge clk);
            if (s_ready) begin
                acc = 1'b1;
                sq.push_back(d);
                push_cyc = cyc + 1;
            end
        end
        chk("push_accept", acc, 1);
        @(posedge clk); #1;
        if (!keep) s_valid = 1'b0;
    endtask

    task automatic commit();
        coeff_commit = 1'b1;
        for (int i = 0; i < 16; i++) cq.push_back(i);
        @(posedge clk); #1;
        coeff_commit = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int t = 0; t < 3000 && !ok; t++) begin
            @(posedge clk); #1;
            ok = (sq.size() == 0) && (cq.size() == 0) && !busy && (fifo_level == 4'd0) && !eng_active;
        end
        chk("wait_idle", ok, 1);
    endtask

    task automatic check_reset_state();
        chk("rst_sample_valid", sample_valid, 0);
        chk("rst_sample_in", sample_in, 0);
        chk("rst_coeff_load", coeff_load, 0);
        chk("rst_coeff_in", coeff_in, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fifo_level", fifo_level, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_s_ready", s_ready, 1);
    endtask

    initial begin
        int base;
        bit ok;
        for (int i = 0; i < 16; i++) mdl_shadow[i] = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state();
        rst = 1'b0;
        @(posedge clk); #1;

        // single sample latency
        base = sv_cnt;
        lat_chk = 1'b1;
        push_one(16'h1234, 1'b0);
        wait_idle();
        lat_chk = 1'b0;
        chk("t1_sv_count", sv_cnt - base, 1);

        // ten samples, s_valid held high
        base = sv_cnt;
        max_level = 0;
        per_chk = 1'b1;
        have_prev = 1'b0;
        for (int k = 0; k < 10; k++) push_one(16'h2000 + 16'(k * 16'h0111), 1'b1);
        s_valid = 1'b0;
        wait_idle();
        per_chk = 1'b0;
        chk("t2_max_level", max_level, 8);
        chk("t2_sv_count", sv_cnt - base, 10);
        chk("t2_level_zero", fifo_level, 0);

        // shadow write, commit during WAIT
        for (int i = 0; i < 16; i++) begin
            coeff_wr = 1'b1; coeff_addr = 4'(i); coeff_wdata = 16'hA000 + 16'(i);
            mdl_shadow[i] = 16'hA000 + 16'(i);
            @(posedge clk); #1;
        end
        coeff_wr = 1'b0;
        base = sv_cnt;
        push_one(16'h5555, 1'b0);
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin @(posedge clk); #1; ok = (sv_cnt > base); end
        chk("t3_first_sv", ok, 1);
        base = load_cnt;
        commit();
        push_one(16'h6666, 1'b0);
        wait_idle();
        chk("t3_loads", load_cnt - base, 16);

        // double commit during a burst plus a live write to entry 15
        c15.delete();
        base = load_cnt;
        commit();
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin @(posedge clk); #1; ok = coeff_load; end
        chk("t4_burst_start", ok, 1);
        coeff_commit = 1'b1;
        for (int i = 0; i < 16; i++) cq.push_back(i);
        @(posedge clk); #1;
        @(posedge clk); #1;
        coeff_commit = 1'b0;
        coeff_wr = 1'b1; coeff_addr = 4'd15; coeff_wdata = 16'hBEEF;
        mdl_shadow[15] = 16'hBEEF;
        @(posedge clk); #1;
        coeff_wr = 1'b0;
        wait_idle();
        chk("t4_loads", load_cnt - base, 32);
        chk("t4_c15_count", c15.size(), 2);
        if (c15.size() != 0) chk("t4_beef_16th", c15[0], 16'hBEEF);

        // watchdog
        eng_on = 1'b0;
        push_one(16'h7777, 1'b0);
        ok = 1'b0;
        for (int t = 0; t < 300 && !ok; t++) begin @(posedge clk); #1; ok = err_timeout; end
        chk("t5_err_set", ok, 1);
        chk("t5_timeout_lat", cyc - last_sv, 64);
        chk("t5_busy_after", busy, 0);
        eng_on = 1'b1;
        base = sv_cnt;
        push_one(16'h8888, 1'b0);
        wait_idle();
        chk("t5_next_sv", sv_cnt - base, 1);
        chk("t5_err_sticky", err_timeout, 1);
        err_clear = 1'b1;
        @(posedge clk); #1;
        err_clear = 1'b0;
        chk("t5_err_cleared", err_timeout, 0);

        // reset in the middle of a burst
        base = load_cnt;
        commit();
        push_one(16'h9999, 1'b0);
        for (int t = 0; t < 100 && (load_cnt - base) < 5; t++) begin @(posedge clk); #1; end
        chk("t6_idx5", load_cnt - base, 5);
        rst = 1'b1;
        sq.delete();
        cq.delete();
        for (int i = 0; i < 16; i++) mdl_shadow[i] = 16'd0;
        @(posedge clk); #1;
        check_reset_state();
        rst = 1'b0;
        @(posedge clk); #1;
        base = load_cnt;
        commit();
        wait_idle();
        chk("t6_zero_burst", load_cnt - base, 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
